// File: rtl/bcd_arb_pkg.sv
// Shared types and helpers for the decimal-indexed grant arbiter.
// Holds the FSM state type, the "no owner" BCD code and the one-hot to BCD helper.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam logic [3:0] NO_GRANT  = 4'hF;
  localparam int         MAX_N_REQ = 10;

  // Returns NO_GRANT for an all-zero vector.
  function automatic logic [3:0] onehot_to_bcd(input logic [MAX_N_REQ-1:0] onehot);
    logic [3:0] id;
    id = NO_GRANT;
    for (int i = 0; i < MAX_N_REQ; i++) begin
      if (onehot[i]) id = 4'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/bcd_grant_arbiter_if.sv
// Request/grant bus between requesters (master side) and the arbiter (slave side).
// dbg_state mirrors the arbiter FSM so checkers can be bound without reaching inside.
interface bcd_grant_arbiter_if
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 10
);

  // Handshake: req bits are levels, no ready. A requester owns the resource
  // while its grant bit is high and releases it by dropping its req bit;
  // the arbiter may also revoke it, signalled by a one-cycle timeout_pulse.
  logic [N_REQ-1:0] req;
  logic             rr_en;
  logic [N_REQ-1:0] grant;
  logic [3:0]       grant_id;
  logic             grant_valid;
  logic             timeout_pulse;
  arb_state_e       dbg_state;

  modport master (
    output req, rr_en,
    input  grant, grant_id, grant_valid, timeout_pulse, dbg_state
  );

  modport slave (
    input  req, rr_en,
    output grant, grant_id, grant_valid, timeout_pulse, dbg_state
  );

endinterface

// File: rtl/bcd_rotate_pick.sv
// Combinational winner pick: first set bit scanning downward from i_rot-1, wrapping,
// reaching i_rot itself last. With i_rot=0 this is plain highest-index priority.
module bcd_rotate_pick
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 10
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [3:0]       i_rot,
  output logic [3:0]       o_id,
  output logic             o_found
);

  always_comb begin
    int               idx;
    logic [N_REQ-1:0] w_shifted;
    o_id      = NO_GRANT;
    o_found   = 1'b0;
    idx       = 0;
    w_shifted = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx       = (int'(i_rot) + N_REQ - k) % N_REQ;
      w_shifted = i_req >> idx;
      if (!o_found && w_shifted[0]) begin
        o_found = 1'b1;
        o_id    = 4'(idx);
      end
    end
  end

endmodule

// File: rtl/bcd_grant_arbiter.sv
// Grant arbiter for up to 10 requesters: fixed-priority or round-robin pick,
// grant held until release or hold-limit timeout, owner reported as a BCD digit.
module bcd_grant_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ    = 10,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic                clk,
  input logic                rst_n,
  bcd_grant_arbiter_if.slave bus
);

  arb_state_e       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [3:0]       r_grant_id;
  logic             r_grant_valid;
  logic             r_timeout_pulse;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_rr_ptr;
  logic [3:0]       r_mask_idx;

  logic [N_REQ-1:0] w_mask_vec;
  logic [N_REQ-1:0] w_unmasked;
  logic [N_REQ-1:0] w_eff_req;
  logic [3:0]       w_rot;
  logic [3:0]       w_pick_id;
  logic             w_pick_found;
  logic             w_owner_req;
  logic             w_hold_max;

  // The timed-out requester is skipped only when someone else is waiting,
  // so a lone requester is simply granted again.
  assign w_mask_vec  = (r_mask_idx == NO_GRANT) ? '0 : (N_REQ'(1) << r_mask_idx);
  assign w_unmasked  = bus.req & ~w_mask_vec;
  assign w_eff_req   = (|w_unmasked) ? w_unmasked : bus.req;
  assign w_rot       = bus.rr_en ? r_rr_ptr : 4'd0;
  assign w_owner_req = |(bus.req & r_grant);
  assign w_hold_max  = (r_hold_cnt == CNT_W'(MAX_HOLD));

  bcd_rotate_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (w_eff_req),
    .i_rot   (w_rot),
    .o_id    (w_pick_id),
    .o_found (w_pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_grant         <= '0;
      r_grant_id      <= NO_GRANT;
      r_grant_valid   <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_hold_cnt      <= '0;
      r_rr_ptr        <= 4'(N_REQ - 1);
      r_mask_idx      <= NO_GRANT;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout_pulse <= 1'b0;
          if (w_pick_found) begin
            r_state       <= GRANT;
            r_grant       <= N_REQ'(1) << w_pick_id;
            r_grant_id    <= w_pick_id;
            r_grant_valid <= 1'b1;
            r_hold_cnt    <= CNT_W'(1);
            r_rr_ptr      <= w_pick_id;
            r_mask_idx    <= NO_GRANT;
          end
        end
        GRANT: begin
          if (!w_owner_req || w_hold_max) begin
            r_state       <= GAP;
            r_grant       <= '0;
            r_grant_id    <= NO_GRANT;
            r_grant_valid <= 1'b0;
            r_hold_cnt    <= '0;
            if (w_owner_req) begin
              r_timeout_pulse <= 1'b1;
              r_mask_idx      <= onehot_to_bcd(MAX_N_REQ'(r_grant));
            end
          end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          r_state         <= IDLE;
          r_timeout_pulse <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant         = r_grant;
  assign bus.grant_id      = r_grant_id;
  assign bus.grant_valid   = r_grant_valid;
  assign bus.timeout_pulse = r_timeout_pulse;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_bcd_grant_arbiter.sv
// Bench for bcd_grant_arbiter: directed scenarios followed by random request traffic,
// every cycle compared against a behavioural owner/cool-down model.
module tb_bcd_grant_arbiter;
  import bcd_arb_pkg::*;

  localparam int N    = 10;
  localparam int MAXH = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_grant_arbiter_if #(.N_REQ(N)) bus ();

  logic [N-1:0] drv_req;
  logic         drv_rr;

  assign bus.req   = drv_req;
  assign bus.rr_en = drv_rr;

  bcd_grant_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MAXH),
    .CNT_W    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // owner: requester holding the grant (-1 none); quiet: dead cycles still to pass
  // before the next arbitration; mask: last timed-out requester (-1 none).
  int m_owner;
  int m_hold;
  int m_ptr;
  int m_mask;
  int m_quiet;
  bit m_pulse;

  int checks;
  int errors;
  logic [15:0] exp_q[$];

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = N - 1;
    m_mask  = -1;
    m_quiet = 0;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] eff;
    int others;
    int w;
    int idx;
    m_pulse = 1'b0;
    if (m_owner >= 0) begin
      if (!bit_of(drv_req, m_owner)) begin
        m_owner = -1;
        m_quiet = 1;
      end else if (m_hold >= MAXH) begin
        m_mask  = m_owner;
        m_owner = -1;
        m_quiet = 1;
        m_pulse = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else begin
      others = 0;
      for (int i = 0; i < N; i++)
        if (bit_of(drv_req, i) && i != m_mask) others++;
      eff = drv_req;
      if (m_mask >= 0 && others > 0) eff = drv_req & ~(10'(1) << m_mask);
      w = -1;
      if (drv_rr) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr - k + N) % N;
          if (w < 0 && bit_of(eff, idx)) w = idx;
        end
      end else begin
        for (int i = N - 1; i >= 0; i--)
          if (w < 0 && bit_of(eff, i)) w = i;
      end
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
        m_ptr   = w;
        m_mask  = -1;
      end
    end
  endtask

  function automatic logic [15:0] model_out();
    logic [N-1:0] g;
    logic [3:0]   id;
    g  = (m_owner >= 0) ? (10'(1) << m_owner) : '0;
    id = (m_owner >= 0) ? 4'(m_owner) : 4'hF;
    return {g, id, (m_owner >= 0), m_pulse};
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag);
    logic [15:0] exp;
    logic [15:0] got;
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    exp_q.push_back(model_out());
    #1;
    exp = exp_q.pop_front();
    got = {bus.grant, bus.grant_id, bus.grant_valid, bus.timeout_pulse};
    chk(tag, 32'(got), 32'(exp));
  endtask

  task automatic drop_bit(input int b);
    drv_req = drv_req & ~(10'(1) << b);
  endtask

  task automatic set_bit(input int b);
    drv_req = drv_req | (10'(1) << b);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int e;
    checks = 0;
    errors = 0;
    model_reset();
    rst_n   = 1'b0;
    drv_rr  = 1'b0;
    drv_req = 10'($urandom_range(0, 1023));

    // reset with random requests
    for (int c = 0; c < 3; c++) step("reset_hold");
    chk("reset_grant", 32'(bus.grant), 32'h0);
    chk("reset_id", 32'(bus.grant_id), 32'hF);
    chk("reset_valid", 32'(bus.grant_valid), 32'h0);
    rst_n   = 1'b1;
    drv_req = '0;
    step("post_reset");
    step("post_reset");
    chk("post_reset_id", 32'(bus.grant_id), 32'hF);

    // fixed priority
    drv_req = 10'b0000100101;
    step("fixed_first");
    chk("fixed_grant", 32'(bus.grant), 32'h020);
    chk("fixed_id5", 32'(bus.grant_id), 32'd5);
    step("fixed_hold");
    drop_bit(5);
    step("fixed_release");
    chk("fixed_gap_valid", 32'(bus.grant_valid), 32'h0);
    step("fixed_idle");
    step("fixed_second");
    chk("fixed_id2", 32'(bus.grant_id), 32'd2);
    drv_req = '0;
    step("fixed_drop");
    step("fixed_gap");
    step("fixed_idle2");

    // round-robin: park the pointer on 0 first so the scan starts at 9
    drv_rr  = 1'b1;
    drv_req = 10'b0000000001;
    step("rr_park");
    chk("rr_park_id", 32'(bus.grant_id), 32'd0);
    drv_req = '0;
    step("rr_park_release");
    step("rr_park_idle");
    drv_req = 10'h3FF;
    for (int g = 0; g <= 10; g++) begin
      e = (g == 10) ? 9 : 9 - g;
      step("rr_grant");
      chk("rr_seq_id", 32'(bus.grant_id), 32'(e));
      step("rr_hold2");
      drop_bit(e);
      step("rr_release");
      chk("rr_gap_valid", 32'(bus.grant_valid), 32'h0);
      set_bit(e);
      step("rr_idle");
      chk("rr_idle_valid", 32'(bus.grant_valid), 32'h0);
    end

    // timeout with a competitor, then masked hand-over and back
    drv_rr  = 1'b0;
    drv_req = 10'b1000001000;
    for (int c = 1; c <= MAXH; c++) begin
      step("to_own9");
      chk("to_id9", 32'(bus.grant_id), 32'd9);
    end
    step("to_pulse9");
    chk("to_pulse9_flag", 32'(bus.timeout_pulse), 32'h1);
    chk("to_pulse9_valid", 32'(bus.grant_valid), 32'h0);
    step("to_idle");
    chk("to_pulse_one_cycle", 32'(bus.timeout_pulse), 32'h0);
    for (int c = 1; c <= MAXH; c++) begin
      step("to_own3");
      chk("to_id3", 32'(bus.grant_id), 32'd3);
    end
    step("to_pulse3");
    step("to_idle3");
    step("to_back9");
    chk("to_back_id9", 32'(bus.grant_id), 32'd9);
    drv_req = '0;
    step("to_drop");
    step("to_gap");
    step("to_idle_end");

    // lone requester times out and is granted again
    drv_req = 10'b0000000001;
    for (int c = 1; c <= MAXH; c++) step("lone_own");
    step("lone_pulse");
    chk("lone_pulse_flag", 32'(bus.timeout_pulse), 32'h1);
    step("lone_idle");
    step("lone_regrant");
    chk("lone_regrant_id", 32'(bus.grant_id), 32'd0);
    drv_req = '0;
    step("lone_drop");
    step("lone_gap");
    step("lone_idle_end");

    // asynchronous reset in the middle of a grant
    drv_rr  = 1'b1;
    drv_req = 10'b0010000000;
    step("ar_grant");
    chk("ar_id7", 32'(bus.grant_id), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_grant", 32'(bus.grant), 32'h0);
    chk("ar_async_id", 32'(bus.grant_id), 32'hF);
    chk("ar_async_pulse", 32'(bus.timeout_pulse), 32'h0);
    model_reset();
    drv_req = 10'h3FF;
    step("ar_in_reset");
    rst_n = 1'b1;
    step("ar_restart");
    chk("ar_restart_id8", 32'(bus.grant_id), 32'd8);

    // random traffic: requests change rarely so holds reach the limit
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       drv_req = '0;
          1:       drv_req = 10'($urandom_range(0, 1023));
          2:       drv_req = 10'(1) << $urandom_range(0, 9);
          default: drv_req = (10'(1) << $urandom_range(0, 9)) | (10'(1) << $urandom_range(0, 9));
        endcase
      end
      if ($urandom_range(0, 7) == 0) drv_rr = 1'($urandom_range(0, 1));
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
